// File: rtl/rr_bcd_lock_arbiter.sv
// Round-robin arbiter with a binary grant index and packet-level locking.
// Optional per-requester grant counters: define RR_ARB_STAT_EN. "release" is a reserved word, so that port is pkt_release.
module rr_bcd_lock_arbiter #(
   parameter int IN_WIDTH  = 4,
   parameter int OUT_WIDTH = $clog2(IN_WIDTH),
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [IN_WIDTH-1:0]  request,
   input  logic                 enable,
   input  logic                 pkt_release,
   output logic [OUT_WIDTH-1:0] grant,
   output logic [IN_WIDTH-1:0]  grant_onehot,
   output logic                 grant_valid,
   output logic                 any_request
`ifdef RR_ARB_STAT_EN
   ,
   output logic [IN_WIDTH*CNT_WIDTH-1:0] grant_cnt
`endif
);

   typedef enum logic {IDLE, LOCKED} state_t;

   localparam logic [OUT_WIDTH-1:0] LastIdx = OUT_WIDTH'(IN_WIDTH - 1);

   if (IN_WIDTH < 2 || CNT_WIDTH < 1) begin : g_param_check
      $error("rr_bcd_lock_arbiter: IN_WIDTH must be >= 2 and CNT_WIDTH >= 1");
   end

   state_t               state, state_nxt;
   logic [OUT_WIDTH-1:0] ptr, ptr_nxt, grant_nxt;
   logic [IN_WIDTH-1:0]  onehot_nxt;
   logic [OUT_WIDTH-1:0] winner, hi_idx, lo_idx;
   logic                 hi_found;
   logic                 start_lock;

   assign any_request = |request;
   assign grant_valid = (state == LOCKED);

   // Lowest requested index at or above ptr wins; otherwise the lowest below ptr.
   // Splitting the search this way makes the wrap happen at IN_WIDTH, never at 2^OUT_WIDTH.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      hi_idx   = '0;
      lo_idx   = '0;
      hi_found = 1'b0;
      for (int i = IN_WIDTH - 1; i >= 0; i--) begin
         if (request[i]) begin
            if (i >= int'(ptr)) begin
               hi_idx   = OUT_WIDTH'(i);
               hi_found = 1'b1;
            end else begin
               lo_idx = OUT_WIDTH'(i);
            end
         end
      end
      winner = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      state_nxt  = state;
      ptr_nxt    = ptr;
      grant_nxt  = grant;
      onehot_nxt = grant_onehot;
      start_lock = 1'b0;
      case (state)
         IDLE: start_lock = enable && any_request;
         LOCKED: begin
            if (pkt_release) begin
               if (enable && any_request) begin
                  start_lock = 1'b1;
               end else begin
                  state_nxt  = IDLE;
                  onehot_nxt = '0;
               end
            end else if (!request[grant]) begin
               state_nxt  = IDLE;
               onehot_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (start_lock) begin
         state_nxt  = LOCKED;
         grant_nxt  = winner;
         onehot_nxt = {{(IN_WIDTH-1){1'b0}}, 1'b1} << winner;
         ptr_nxt    = (winner == LastIdx) ? '0 : winner + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (!reset_n) begin
         state        <= IDLE;
         ptr          <= '0;
         grant        <= '0;
         grant_onehot <= '0;
      end else begin
         state        <= state_nxt;
         ptr          <= ptr_nxt;
         grant        <= grant_nxt;
         grant_onehot <= onehot_nxt;
      end
   end

`ifdef RR_ARB_STAT_EN
   logic [CNT_WIDTH-1:0] cnt [IN_WIDTH];

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: the counter array is reset explicitly; counts must read zero after reset.
      if (!reset_n) begin
         for (int i = 0; i < IN_WIDTH; i++) cnt[i] <= '0;
      end else if (start_lock && cnt[winner] != '1) begin
         cnt[winner] <= cnt[winner] + 1'b1;
      end
   end

   for (genvar g = 0; g < IN_WIDTH; g++) begin : g_cnt_pack
      assign grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
   end
`endif

endmodule

// File: tb/tb_rr_bcd_lock_arbiter.sv
// Self-checking bench: a 4-requester arbiter (2-bit counters) and a 3-requester arbiter,
// compared every cycle against a spec-level model plus directed literal expectations.
module tb_rr_bcd_lock_arbiter;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] req = '0;
   logic       en = 1'b0, rel = 1'b0;
   logic [1:0] grant_a;
   logic [3:0] onehot_a;
   logic       valid_a, any_a;
   logic [2:0] b_req = '0;
   logic       b_en = 1'b0, b_rel = 1'b0;
   logic [1:0] grant_b;
   logic [2:0] onehot_b;
   logic       valid_b, any_b;
`ifdef RR_ARB_STAT_EN
   logic [7:0]  cnt_a;
   logic [23:0] cnt_b;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rr_bcd_lock_arbiter #(.IN_WIDTH(4), .CNT_WIDTH(2)) dut_a (
      .clk(clk), .reset_n(reset_n), .request(req), .enable(en), .pkt_release(rel),
      .grant(grant_a), .grant_onehot(onehot_a), .grant_valid(valid_a), .any_request(any_a)
`ifdef RR_ARB_STAT_EN
      , .grant_cnt(cnt_a)
`endif
   );

   rr_bcd_lock_arbiter #(.IN_WIDTH(3)) dut_b (
      .clk(clk), .reset_n(reset_n), .request(b_req), .enable(b_en), .pkt_release(b_rel),
      .grant(grant_b), .grant_onehot(onehot_b), .grant_valid(valid_b), .any_request(any_b)
`ifdef RR_ARB_STAT_EN
      , .grant_cnt(cnt_b)
`endif
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Spec-level model: owner/pointer kept as plain integers, search done with modular arithmetic.
   task automatic model_step(input bit v, input int g, input int p, input logic [3:0] rq,
                             input bit e, input bit rl, input int n,
                             output bit v_o, output int g_o, output int p_o, output int won);
      bit any_rq = 1'b0;
      bit start  = 1'b0;
      for (int i = 0; i < n; i++) if (rq[i]) any_rq = 1'b1;
      v_o = v; g_o = g; p_o = p; won = -1;
      if (!v)           start = e && any_rq;
      else if (rl) begin
         if (e && any_rq) start = 1'b1;
         else             v_o = 1'b0;
      end
      else if (!rq[g])  v_o = 1'b0;
      if (start) begin
         for (int k = n - 1; k >= 0; k--) if (rq[(p + k) % n]) won = (p + k) % n;
         v_o = 1'b1;
         g_o = won;
         p_o = (won + 1) % n;
      end
   endtask

   bit ma_valid, mb_valid;
   int ma_grant, ma_ptr, mb_grant, mb_ptr, won_a, won_b;
   int ma_cnt [4];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ma_valid = 1'b0; ma_grant = 0; ma_ptr = 0;
         mb_valid = 1'b0; mb_grant = 0; mb_ptr = 0;
         for (int i = 0; i < 4; i++) ma_cnt[i] = 0;
      end else begin
         model_step(ma_valid, ma_grant, ma_ptr, req, en, rel, 4, ma_valid, ma_grant, ma_ptr, won_a);
         if (won_a >= 0 && ma_cnt[won_a] < 3) ma_cnt[won_a]++;
         model_step(mb_valid, mb_grant, mb_ptr, {1'b0, b_req}, b_en, b_rel, 3,
                    mb_valid, mb_grant, mb_ptr, won_b);
      end
   end

   always @(negedge clk) begin
      check("a_valid",  valid_a,  ma_valid);
      check("a_grant",  grant_a,  ma_grant);
      check("a_onehot", onehot_a, ma_valid ? (1 << ma_grant) : 0);
      check("a_any",    any_a,    (req != 0));
      check("b_valid",  valid_b,  mb_valid);
      check("b_grant",  grant_b,  mb_grant);
      check("b_onehot", onehot_b, mb_valid ? (1 << mb_grant) : 0);
      check("b_any",    any_b,    (b_req != 0));
`ifdef RR_ARB_STAT_EN
      for (int i = 0; i < 4; i++) check("a_cnt", cnt_a[i*2 +: 2], ma_cnt[i]);
`endif
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_a(input string name, input bit v, input int g);
      check({name, "_valid"},  valid_a,  v);
      check({name, "_grant"},  grant_a,  g);
      check({name, "_onehot"}, onehot_a, v ? (1 << g) : 0);
   endtask

   task automatic expect_b(input string name, input bit v, input int g);
      check({name, "_valid"},  valid_b,  v);
      check({name, "_grant"},  grant_b,  g);
      check({name, "_onehot"}, onehot_b, v ? (1 << g) : 0);
   endtask

   int stat_exp [5] = '{1, 2, 3, 3, 3};

   initial begin
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      expect_a("reset", 0, 0);

      // Rotation: 0,1,2,3,0 with release every second cycle, no idle gap.
      req = 4'b1111; en = 1'b1;
      tick();
      for (int r = 0; r < 5; r++) begin
         expect_a("rr", 1, r % 4);
         tick();
         expect_a("rr_hold", 1, r % 4);
         if (r < 4) begin
            rel = 1'b1; tick(); rel = 1'b0;
         end
      end

      // Lock hold on requester 1, then release with enable low.
      rel = 1'b1; tick(); rel = 1'b0;
      req = 4'b1011;
      repeat (5) begin
         tick();
         expect_a("hold", 1, 1);
      end
      rel = 1'b1; en = 1'b0;
      tick();
      expect_a("hold_rel", 0, 1);
      rel = 1'b0; en = 1'b1;

      // Abort and skip: ptr=2, only requester 0.
      req = 4'b0001; tick(); expect_a("skip", 1, 0);
      req = 4'b0000; tick(); expect_a("abort", 0, 0);
      req = 4'b1111; tick(); expect_a("ptr_kept", 1, 1);
      req = 4'b0000; tick(); expect_a("abort2", 0, 1);

      // Release ignored in IDLE; no arbitration with enable low.
      rel = 1'b1; tick(); expect_a("idle_rel", 0, 1);
      rel = 1'b0; en = 1'b0; req = 4'b1111; tick(); expect_a("idle_noen", 0, 1);

      // Sole requester re-wins after its own release; ptr wraps at 4.
      en = 1'b1; req = 4'b1000; tick(); expect_a("sole", 1, 3);
      rel = 1'b1; tick(); expect_a("sole_rearb", 1, 3);

      // Reset in the middle of a lock held by requester 2.
      req = 4'b0100; tick(); expect_a("lock2", 1, 2);
      rel = 1'b0; tick(); expect_a("lock2_hold", 1, 2);
      #1 reset_n = 1'b0;
      #1 expect_a("async_rst", 0, 0);
      @(posedge clk);
      #2 req = 4'b1111; reset_n = 1'b1;
      tick(); expect_a("post_rst", 1, 0);

      // Five separate locks for requester 3, then one long lock for requester 1.
      req = 4'b1000; rel = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         expect_a("stat", 1, 3);
`ifdef RR_ARB_STAT_EN
         check("stat_cnt3", cnt_a[7:6], stat_exp[k]);
`endif
      end
      req = 4'b0010; tick(); expect_a("long", 1, 1);
      rel = 1'b0;
      repeat (10) tick();
      expect_a("long_hold", 1, 1);
`ifdef RR_ARB_STAT_EN
      check("long_cnt1", cnt_a[3:2], 1);
`endif
      rel = 1'b1; en = 1'b0; tick(); expect_a("long_rel", 0, 1);
      rel = 1'b0;

      // Three requesters: wrap at 3, index 3 never produced.
      b_en = 1'b1; b_req = 3'b100; tick(); expect_b("b_single", 1, 2);
      b_rel = 1'b1; b_req = 3'b000; tick(); expect_b("b_rel", 0, 2);
      b_rel = 1'b0; b_req = 3'b101; tick(); expect_b("b_wrap", 1, 0);
      b_rel = 1'b1; tick(); expect_b("b_next", 1, 2);
      tick(); expect_b("b_wrap2", 1, 0);
      b_rel = 1'b0; b_req = 3'b000; tick(); expect_b("b_abort", 0, 0);

      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
